// File: rtl/axis_arbiter_pkg.sv
// Shared types and helpers for the packet-granular AXI4-Stream arbiter.
package axis_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

    // Width of an index into n items; never narrower than one bit.
    function automatic int index_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/axis_rr_select.sv
// Combinational round-robin picker: rotate the request vector so the
// search starts just above last_grant, priority-encode, then un-rotate.
module axis_rr_select
    import axis_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS = 2,
    parameter int IW         = 1
) (
    input  logic [NUM_INPUTS-1:0] req,
    input  logic [IW-1:0]         last_grant,
    output logic                  found,
    output logic [IW-1:0]         index
);

    logic [NUM_INPUTS-1:0] rotated;

    // Rotate: rotated[0] is the input right after last_grant.
    always_comb begin
        logic [IW-1:0] src;
        rotated = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            src        = IW'((int'(last_grant) + 1 + k) % NUM_INPUTS);
            rotated[k] = req[src];
        end
    end

    // Priority encode the rotated vector and map the winner back.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        found = 1'b0;
        index = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (rotated[k] && !found) begin
                found = 1'b1;
                index = IW'((int'(last_grant) + 1 + k) % NUM_INPUTS);
            end
        end
    end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter: NUM_INPUTS AXI4-Stream requesters
// share one master. A grant is held until the tlast beat is accepted, and
// arbitration costs one idle cycle between packets.
// Optional per-input packet counters: define AXIS_PACKET_ARBITER_STATS_EN.
module axis_packet_arbiter
    import axis_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS = 2,
    parameter int DATA_WIDTH = 1,
    parameter int USER_WIDTH = 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_INPUTS*DATA_WIDTH*8-1:0] s_tdata,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] s_tkeep,
    input  logic [NUM_INPUTS*USER_WIDTH-1:0] s_tuser,
    input  logic [NUM_INPUTS-1:0]            s_tlast,
    input  logic [NUM_INPUTS-1:0]            s_tvalid,
    output logic [NUM_INPUTS-1:0]            s_tready,
    output logic [DATA_WIDTH*8-1:0]          m_tdata,
    output logic [DATA_WIDTH-1:0]            m_tkeep,
    output logic [USER_WIDTH-1:0]            m_tuser,
    output logic                             m_tlast,
    output logic                             m_tvalid,
    input  logic                             m_tready,
    output logic [$clog2(NUM_INPUTS)-1:0]    grant_index,
`ifdef AXIS_PACKET_ARBITER_STATS_EN
    output logic [NUM_INPUTS*32-1:0]         packet_count,
`endif
    output logic                             busy
);

    localparam int IW  = index_width(NUM_INPUTS);
    localparam int DW8 = DATA_WIDTH * 8;

    arb_state_t    state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] last_q, last_d;
    logic          busy_q, busy_d;

    logic          sel_found;
    logic [IW-1:0] sel_index;
    logic          beat_end;

    axis_rr_select #(
        .NUM_INPUTS (NUM_INPUTS),
        .IW         (IW)
    ) u_select (
        .req        (s_tvalid),
        .last_grant (last_q),
        .found      (sel_found),
        .index      (sel_index)
    );

    // Combinational data path from the granted input while BUSY.
    always_comb begin
        m_tdata           = s_tdata[grant_q*DW8 +: DW8];
        m_tkeep           = s_tkeep[grant_q*DATA_WIDTH +: DATA_WIDTH];
        m_tuser           = s_tuser[grant_q*USER_WIDTH +: USER_WIDTH];
        m_tlast           = s_tlast[grant_q];
        m_tvalid          = busy_q & s_tvalid[grant_q];
        s_tready          = '0;
        s_tready[grant_q] = busy_q & m_tready;
    end

    assign beat_end = m_tvalid & m_tready & m_tlast;

    // Next-state logic: grant on any request in IDLE, release on the tlast beat.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        busy_d  = busy_q;
        case (state_q)
            ARB_IDLE: begin
                if (sel_found) begin
                    state_d = ARB_BUSY;
                    grant_d = sel_index;
                    busy_d  = 1'b1;
                end
            end
            ARB_BUSY: begin
                if (beat_end) begin
                    state_d = ARB_IDLE;
                    last_d  = grant_q;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // FSM and grant registers; last_grant resets so input 0 wins first.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            last_q  <= IW'(NUM_INPUTS - 1);
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    assign grant_index = grant_q;
    assign busy        = busy_q;

`ifdef AXIS_PACKET_ARBITER_STATS_EN
    logic [31:0] count_q [NUM_INPUTS];
    logic [31:0] count_d [NUM_INPUTS];

    // Count accepted tlast beats of the granted input; wraps modulo 2^32.
    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            count_d[i] = count_q[i];
        end
        if (beat_end) begin
            count_d[grant_q] = count_q[grant_q] + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: the counter array is plain flops, not RAM, so it can and must be cleared on reset.
        if (reset) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                count_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                count_q[i] <= count_d[i];
            end
        end
    end

    // Flatten the counters onto the output port.
    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            packet_count[i*32 +: 32] = count_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Self-checking bench for axis_packet_arbiter (NUM_INPUTS=4, 1-byte data).
// Checks packet_count as well when AXIS_PACKET_ARBITER_STATS_EN is defined.
module tb_axis_packet_arbiter;

    localparam int NI = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [NI*8-1:0] s_tdata;
    logic [NI-1:0]   s_tkeep;
    logic [NI-1:0]   s_tuser;
    logic [NI-1:0]   s_tlast;
    logic [NI-1:0]   s_tvalid;
    logic [NI-1:0]   s_tready;
    logic [7:0]      m_tdata;
    logic [0:0]      m_tkeep;
    logic [0:0]      m_tuser;
    logic            m_tlast;
    logic            m_tvalid;
    logic            m_tready;
    logic [1:0]      grant_index;
    logic            busy;
`ifdef AXIS_PACKET_ARBITER_STATS_EN
    logic [NI*32-1:0] packet_count;
`endif

    axis_packet_arbiter #(
        .NUM_INPUTS (NI),
        .DATA_WIDTH (1),
        .USER_WIDTH (1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .s_tdata      (s_tdata),
        .s_tkeep      (s_tkeep),
        .s_tuser      (s_tuser),
        .s_tlast      (s_tlast),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .m_tdata      (m_tdata),
        .m_tkeep      (m_tkeep),
        .m_tuser      (m_tuser),
        .m_tlast      (m_tlast),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .grant_index  (grant_index),
`ifdef AXIS_PACKET_ARBITER_STATS_EN
        .packet_count (packet_count),
`endif
        .busy         (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    // ---------------- source queues and reference model ----------------
    typedef struct {
        logic [7:0] data;
        logic       keep;
        logic       user;
        logic       last;
    } beat_t;

    typedef struct {
        int         src;
        logic [7:0] data;
        logic       last;
        int         cyc;
    } obs_t;

    beat_t srcq [NI][$];
    obs_t  out_log[$];
    int    owner;      // input holding the grant, -1 while arbitrating
    int    last_g;     // input served most recently
    int    exp_gidx;   // expected grant_index value
    int    cnt [NI];   // packets completed per input
    int    cyc = 0;
    int    gen_beats;

    task automatic add_packet(input int src, input int n, input logic [7:0] base);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.data = base + 8'(k);
            b.keep = $urandom_range(0, 1) == 1;
            b.user = $urandom_range(0, 1) == 1;
            b.last = (k == n - 1);
            srcq[src].push_back(b);
        end
        gen_beats += n;
    endtask

    function automatic int queued();
        int s = 0;
        for (int i = 0; i < NI; i++) s += srcq[i].size();
        return s;
    endfunction

    // One clock cycle: drive sources, compare outputs with the model, advance.
    task automatic tick(input logic rdy, input logic [NI-1:0] gap);
        int          pick;
        logic        xfer;
        logic [NI-1:0] exp_rdy;
        beat_t       b;
        @(negedge clock);
        for (int i = 0; i < NI; i++) begin
            if (srcq[i].size() > 0 && !gap[i]) begin
                s_tvalid[i]       = 1'b1;
                s_tdata[i*8 +: 8] = srcq[i][0].data;
                s_tkeep[i]        = srcq[i][0].keep;
                s_tuser[i]        = srcq[i][0].user;
                s_tlast[i]        = srcq[i][0].last;
            end else begin
                s_tvalid[i]       = 1'b0;
                s_tdata[i*8 +: 8] = 8'h00;
                s_tkeep[i]        = 1'b0;
                s_tuser[i]        = 1'b0;
                s_tlast[i]        = 1'b0;
            end
        end
        m_tready = rdy;
        #1;
        pick = -1;
        if (owner < 0) begin
            check("idle_busy", busy, 0);
            check("idle_m_tvalid", m_tvalid, 0);
            check("idle_s_tready", s_tready, 0);
            check("idle_grant_index", grant_index, exp_gidx);
            for (int k = 1; k <= NI; k++) begin
                if (pick < 0 && s_tvalid[(last_g + k) % NI]) pick = (last_g + k) % NI;
            end
        end else begin
            exp_rdy = '0;
            if (rdy) exp_rdy[owner] = 1'b1;
            check("busy_busy", busy, 1);
            check("busy_grant_index", grant_index, owner);
            check("busy_m_tvalid", m_tvalid, s_tvalid[owner]);
            check("busy_s_tready", s_tready, exp_rdy);
            if (s_tvalid[owner]) begin
                check("m_tdata", m_tdata, srcq[owner][0].data);
                check("m_tkeep", m_tkeep, srcq[owner][0].keep);
                check("m_tuser", m_tuser, srcq[owner][0].user);
                check("m_tlast", m_tlast, srcq[owner][0].last);
            end
        end
        xfer = (owner >= 0) && s_tvalid[owner] && rdy;
        @(posedge clock);
        cyc++;
        if (owner < 0) begin
            if (pick >= 0) begin
                owner    = pick;
                exp_gidx = pick;
            end
        end else if (xfer) begin
            b = srcq[owner].pop_front();
            out_log.push_back('{owner, b.data, b.last, cyc});
            if (b.last) begin
                cnt[owner]++;
                last_g = owner;
                owner  = -1;
            end
        end
    endtask

    // Assert reset (outputs checked while it is high), then restart the model.
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_s_tready", s_tready, 0);
        check("rst_grant_index", grant_index, 0);
        s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tuser = '0; s_tlast = '0;
        m_tready = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < NI; i++) begin
            srcq[i].delete();
            cnt[i] = 0;
        end
        out_log.delete();
        owner     = -1;
        last_g    = NI - 1;
        exp_gidx  = 0;
        gen_beats = 0;
    endtask

    function automatic int cnt_sum();
        int s = 0;
        for (int i = 0; i < NI; i++) s += cnt[i];
        return s;
    endfunction

    // ---------------- arbitration vector table ----------------
    typedef struct {
        logic [NI-1:0] mask;
        int            exp_g;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int            rr_order [5];
        logic          bp_rdy   [7];
        logic [NI-1:0] bp_gap   [7];
        logic [7:0]    bp_data  [5];
        logic [NI-1:0] exp_r;

        // Single-beat packets, one arbitration each; last_grant carries over.
        vecs[0] = '{4'b1111, 0};
        vecs[1] = '{4'b1111, 1};
        vecs[2] = '{4'b1010, 3};
        vecs[3] = '{4'b0110, 1};
        vecs[4] = '{4'b0001, 0};
        vecs[5] = '{4'b1000, 3};
        vecs[6] = '{4'b0101, 0};
        vecs[7] = '{4'b0100, 2};
        vecs[8] = '{4'b1001, 3};
        vecs[9] = '{4'b0010, 1};
        rr_order = '{0, 1, 2, 3, 0};
        bp_rdy   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        bp_gap   = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
        bp_data  = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h05};

        s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tuser = '0; s_tlast = '0;
        m_tready = 1'b0;

        // Reset defaults.
        do_reset();

        // Table-driven arbitration order.
        for (int v = 0; v < 10; v++) begin
            @(negedge clock);
            s_tvalid = vecs[v].mask;
            s_tlast  = '1;
            s_tkeep  = '1;
            s_tuser  = '0;
            m_tready = 1'b0;
            for (int i = 0; i < NI; i++) s_tdata[i*8 +: 8] = 8'hA0 + 8'(i);
            #1;
            check("vec_idle_busy", busy, 0);
            check("vec_idle_m_tvalid", m_tvalid, 0);
            @(negedge clock);
            #1;
            check("vec_grant_index", grant_index, vecs[v].exp_g);
            check("vec_busy", busy, 1);
            check("vec_m_tvalid", m_tvalid, 1);
            check("vec_m_tdata", m_tdata, 8'hA0 + 8'(vecs[v].exp_g));
            check("vec_s_tready_stalled", s_tready, 0);
            m_tready = 1'b1;
            #1;
            exp_r = '0;
            exp_r[vecs[v].exp_g] = 1'b1;
            check("vec_s_tready", s_tready, exp_r);
            @(negedge clock);
            s_tvalid = '0;
            m_tready = 1'b0;
            #1;
            check("vec_release_busy", busy, 0);
        end

        // Round-robin order with 3-beat packets from all inputs.
        do_reset();
        for (int i = 0; i < NI; i++) begin
            add_packet(i, 3, 8'(i * 16));
            add_packet(i, 3, 8'(i * 16));
        end
        for (int n = 0; n < 100 && cnt_sum() < 5; n++) tick(1'b1, '0);
        check("rr_packets", cnt_sum(), 5);
        check("rr_beats", out_log.size(), 15);
        if (out_log.size() >= 15) begin
            for (int j = 0; j < 15; j++) begin
                check("rr_src", out_log[j].src, rr_order[j / 3]);
                check("rr_data", out_log[j].data, 8'(rr_order[j / 3] * 16 + j % 3));
                if (j > 0) check("rr_spacing", out_log[j].cyc - out_log[j-1].cyc, (j % 3 == 0) ? 2 : 1);
            end
        end
`ifdef AXIS_PACKET_ARBITER_STATS_EN
        check("stats_rr_in0", packet_count[31:0], 2);
        check("stats_rr_in1", packet_count[63:32], 1);
        check("stats_rr_in2", packet_count[95:64], 1);
        check("stats_rr_in3", packet_count[127:96], 1);
`endif
        for (int n = 0; n < 200 && (queued() > 0 || owner >= 0); n++) tick(1'b1, '0);
        check("rr_drained", queued(), 0);

        // Single requester, single-beat packets.
        out_log.delete();
        for (int k = 0; k < 5; k++) add_packet(2, 1, 8'h20 + 8'(k));
        for (int n = 0; n < 60 && out_log.size() < 5; n++) tick(1'b1, '0);
        tick(1'b1, '0);
        check("single_beats", out_log.size(), 5);
        if (out_log.size() >= 5) begin
            for (int k = 0; k < 5; k++) begin
                check("single_src", out_log[k].src, 2);
                check("single_data", out_log[k].data, 8'h20 + 8'(k));
                if (k > 0) check("single_spacing", out_log[k].cyc - out_log[k-1].cyc, 2);
            end
        end
        check("single_grant_index", grant_index, 2);

        // Backpressure and mid-packet tvalid drop; input 0 waits for tlast.
        do_reset();
        add_packet(1, 4, 8'h10);
        tick(1'b1, '0);
        add_packet(0, 1, 8'h05);
        for (int c = 0; c < 7; c++) tick(bp_rdy[c], bp_gap[c]);
        for (int n = 0; n < 20 && out_log.size() < 5; n++) tick(1'b1, '0);
        check("bp_beats", out_log.size(), 5);
        if (out_log.size() >= 5) begin
            for (int k = 0; k < 5; k++) begin
                check("bp_data", out_log[k].data, bp_data[k]);
                check("bp_src", out_log[k].src, (k < 4) ? 1 : 0);
            end
            check("bp_stall_span", out_log[2].cyc - out_log[1].cyc, 4);
            check("bp_handover", out_log[4].cyc - out_log[3].cyc, 2);
        end

        // Reset in the middle of a packet from input 3.
        do_reset();
        add_packet(3, 4, 8'h30);
        tick(1'b1, '0);
        tick(1'b1, '0);
        tick(1'b1, '0);
        check("mid_beats_before_reset", out_log.size(), 2);
        do_reset();
        add_packet(3, 2, 8'h38);
        add_packet(0, 2, 8'h00);
        for (int n = 0; n < 40 && (queued() > 0 || owner >= 0); n++) tick(1'b1, '0);
        check("mid_after_beats", out_log.size(), 4);
        if (out_log.size() >= 4) begin
            check("mid_first_src", out_log[0].src, 0);
            check("mid_second_src", out_log[2].src, 3);
            check("mid_second_data", out_log[2].data, 8'h38);
        end

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                add_packet(int'($urandom_range(0, NI - 1)), int'($urandom_range(1, 5)), 8'($urandom));
            end
            tick($urandom_range(0, 3) != 0, '0);
        end
        for (int n = 0; n < 1000 && (queued() > 0 || owner >= 0); n++) tick(1'b1, '0);
        check("rand_drained", queued(), 0);
        check("rand_beats", out_log.size(), gen_beats);
`ifdef AXIS_PACKET_ARBITER_STATS_EN
        for (int i = 0; i < NI; i++) check("stats_rand", packet_count[i*32 +: 32], cnt[i]);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_packet_arbiter.md
# axis_packet_arbiter

Packet-granular round-robin arbiter sharing one AXI4-Stream master between NUM_INPUTS AXI4-Stream requesters, for example several frame builders feeding a single Ethernet MAC TX stream. A grant is held from the first beat of a packet until the beat with tlast is accepted, so packets are never interleaved. The data path is combinational while a grant is held. Arbitration costs one idle cycle between packets.

## Interface
Parameters:
- NUM_INPUTS, 2 — number of requesters; legal range 2..16.
- DATA_WIDTH, 1 — TDATA width in bytes; TKEEP width in bits.
- USER_WIDTH, 1 — TUSER width in bits.

Ports (`*` = per-input vector, input i in slice i):
- Clocking and reset: one clock; reset is asynchronous and active-high.
- clock  in  1  — single clock; all logic on the rising edge.
- reset  in  1  — asynchronous, active-high reset.
- s_tdata*  in  NUM_INPUTS*DATA_WIDTH*8  — requester data.
- s_tkeep*  in  NUM_INPUTS*DATA_WIDTH  — requester byte enables.
- s_tuser*  in  NUM_INPUTS*USER_WIDTH  — requester sideband.
- s_tlast*  in  NUM_INPUTS  — requester end of packet.
- s_tvalid*  in  NUM_INPUTS  — requester valid.
- s_tready*  out  NUM_INPUTS  — one-hot or zero; high only for the granted input.
- m_tdata, m_tkeep, m_tuser, m_tlast  out  as above  — muxed from the granted input.
- m_tvalid  out  1  — granted input's tvalid while BUSY.
- m_tready  in  1  — downstream ready.
- grant_index  out  $clog2(NUM_INPUTS)  — currently or last granted input.
- busy  out  1  — high while in BUSY.

## Operation
States:
- **IDLE:** m_tvalid = 0 and all s_tready = 0.
  - If any s_tvalid is high, pick the first requesting input found searching upward from last_grant+1, modulo NUM_INPUTS.
  - Register the pick into grant_index and go to BUSY.
  - With no request, stay in IDLE.
- **BUSY:**
  - m_* = s_*[grant_index].
  - s_tready[grant_index] = m_tready; all other s_tready = 0.
  - A beat transfers when m_tvalid && m_tready.
  - A transfer with m_tlast = 1 returns to IDLE, and last_grant <= grant_index.

Rules and boundary cases:
- Selection uses only tvalid. A requester must hold tvalid and its data until accepted (AXI rule); the arbiter does not check this.
- Granted input drops tvalid mid-packet: the grant is kept and m_tvalid follows it low. There is no timeout.
- Single-beat packet (tlast on the first beat): BUSY lasts one accepted beat, then IDLE.
- Only one requester active: it is re-granted after each packet, still paying the one IDLE cycle.
- Round-robin wrap: after input NUM_INPUTS-1 is served, the search starts at input 0.
- Reset mid-packet: the packet is abandoned, with no flush or recovery. The downstream sees a truncated packet with no tlast.

## Timing
Reset values:
- state = IDLE, grant_index = 0, last_grant = NUM_INPUTS-1 (so input 0 wins first), busy = 0, m_tvalid = 0, s_tready = 0.
- m_tdata, m_tkeep, m_tuser and m_tlast are don't-care while m_tvalid = 0.

Latency and throughput:
- Arbitration: tvalid seen in IDLE at edge N means the first beat can transfer at edge N+1.
- BUSY: 0-cycle combinational path between s_* and m_*, and m_tready to s_tready. The downstream must not make m_tready depend combinationally on m_tvalid.
- Throughput is one beat per cycle inside a packet. Back-to-back packets have exactly one bubble cycle between them.

## Configuration
Macro AXIS_PACKET_ARBITER_STATS_EN.
- **Defined:**
  - Adds output port packet_count (NUM_INPUTS*32 bits): one 32-bit counter per input.
  - A counter increments on each accepted tlast beat from its input and wraps modulo 2^32.
  - Counters reset to 0.
- **Undefined:** the port and the counters are absent; all other behaviour is identical.

## Structure
- Package axis_arbiter_pkg:
  - state enum arb_state_t {ARB_IDLE, ARB_BUSY}.
  - Localparam-style index width function index_width(n) = max(1, $clog2(n)).
- Sub-module axis_rr_select: combinational round-robin picker.
  - Inputs: request vector and last_grant.
  - Outputs: found and index.
  - Implemented as a rotate, then priority encode, then un-rotate.
- The top level holds the FSM, the grant register, the mux and the optional counters.

## Test plan
- **Reset defaults:** during and after reset with all inputs idle, busy = 0, m_tvalid = 0, s_tready = 0, grant_index = 0.
- **Round-robin order:** NUM_INPUTS=4, all inputs continuously offer 3-beat packets (data 0xi0..0xi2, tlast on beat 2). Output packet order is 0,1,2,3,0, with one bubble cycle between packets and no interleaved beats.
- **Single requester and single-beat packets:** only input 2 sends five 1-beat packets. Output is five beats, each followed by one idle cycle; grant_index = 2 throughout.
- **Backpressure and stall:** input 1 sends a 4-beat packet; m_tready is low on cycles 2–3 and input 1 drops tvalid for one mid-packet cycle. Output data is unchanged and in order, and input 0's pending request waits until tlast is accepted.
- **Reset mid-packet:** assert reset after beat 1 of a 4-beat packet from input 3. The FSM returns to IDLE immediately and a later request from input 0 is granted first.
- **Stats (AXIS_PACKET_ARBITER_STATS_EN defined):** after the round-robin test, packet_count = {5? per served count}. Input 0 reads 2 and inputs 1–3 read 1 each after five packets.
